// File: rtl/key_input_ctrl_pkg.sv
// Shared constants for the front-panel key path.
//   - Mode encoding, shared with the timekeeping top level and the display
//     path so every block agrees on what each Mode value means.
//   - Key index constants, used to address the per-key vectors.
//   - next_mode(): wrap-around step of the Mode counter.
package key_input_ctrl_pkg;

  localparam int MODE_W = 6;

  // Mode encoding. Values 2..5 are the remaining steps up to the default MODE_MAX.
  localparam logic [MODE_W-1:0] MODE_NORMAL = 6'd0;
  localparam logic [MODE_W-1:0] MODE_SET    = 6'd1;
  localparam logic [MODE_W-1:0] MODE_2      = 6'd2;
  localparam logic [MODE_W-1:0] MODE_3      = 6'd3;
  localparam logic [MODE_W-1:0] MODE_4      = 6'd4;
  localparam logic [MODE_W-1:0] MODE_5      = 6'd5;

  // Key indices into the per-key vectors.
  localparam int KEY_MODE = 0;
  localparam int KEY_RESH = 1;
  localparam int KEY_RESL = 2;
  localparam int KEY_ADDH = 3;
  localparam int KEY_ADDL = 4;
  localparam int NUM_KEYS = 5;

  // Advance Mode by one, wrapping from max_mode back to MODE_NORMAL.
  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] cur,
                                                   input logic [MODE_W-1:0] max_mode);
    return (cur == max_mode) ? MODE_NORMAL : cur + 6'd1;
  endfunction

endpackage

// File: rtl/key_input_ctrl_if.sv
// Front-panel key bundle between the panel side and key_input_ctrl.
//   SampleEn      debounce sample tick (from the frequency divider)
//   *KeyRaw       raw buttons, active-low, asynchronous
//   Mode          current mode, 0..MODE_MAX
//   ModePulse     one-cycle pulse per accepted mode press
//   ResH/ResL     debounced clears, active-high while held
//   AddHKey/AddLKey debounced advances, active-low while held
// master: panel/stimulus side (drives raw keys and the tick).
// slave:  key_input_ctrl.
interface key_input_ctrl_if;
  import key_input_ctrl_pkg::*;

  logic              SampleEn;
  logic              ModeKeyRaw;
  logic              ResHKeyRaw;
  logic              ResLKeyRaw;
  logic              AddHKeyRaw;
  logic              AddLKeyRaw;
  logic [MODE_W-1:0] Mode;
  logic              ModePulse;
  logic              ResH;
  logic              ResL;
  logic              AddHKey;
  logic              AddLKey;

  modport master (
    output SampleEn, ModeKeyRaw, ResHKeyRaw, ResLKeyRaw, AddHKeyRaw, AddLKeyRaw,
    input  Mode, ModePulse, ResH, ResL, AddHKey, AddLKey
  );

  modport slave (
    input  SampleEn, ModeKeyRaw, ResHKeyRaw, ResLKeyRaw, AddHKeyRaw, AddLKeyRaw,
    output Mode, ModePulse, ResH, ResL, AddHKey, AddLKey
  );
endinterface

// File: rtl/key_input_ctrl_key_debounce.sv
// key_debounce: two-flop synchroniser plus tick-gated debounce for one
// active-low key.
//   CP        clock
//   CR        asynchronous active-high reset
//   SampleEn  debounce sample tick
//   raw_n     raw key level (asynchronous)
//   stable_n  debounced level; 1 = released
// The stable level flips only after the synchronised level has differed from
// it on DEB_CNT consecutive ticks; any return to the stable level restarts
// the count, on every cycle regardless of SampleEn.
module key_debounce #(
  parameter int DEB_CNT = 20
) (
  input  logic CP,
  input  logic CR,
  input  logic SampleEn,
  input  logic raw_n,
  output logic stable_n
);

  localparam int CW = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of the others (sync[1] here is last cycle's sample).
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      sync     <= 2'b11;
      cnt      <= '0;
      stable_n <= 1'b1;
    end else begin
      sync <= {sync[0], raw_n};
      if (sync[1] == stable_n) begin
        cnt <= '0;
      end else if (SampleEn) begin
        if (cnt == CNT_LAST) begin
          stable_n <= sync[1];
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/key_input_ctrl.sv
// key_input_ctrl: conditions the five front-panel buttons and sequences Mode.
//   CP   clock (1 kHz domain)
//   CR   asynchronous active-high reset
//   bus  key_input_ctrl_if.slave: raw keys + SampleEn in; Mode, ModePulse,
//        ResH, ResL, AddHKey, AddLKey out.
// Outputs depend only on registered state; no raw input reaches an output
// combinationally.
module key_input_ctrl
  import key_input_ctrl_pkg::*;
#(
  parameter int DEB_CNT  = 20,
  parameter int MODE_MAX = 5
) (
  input  logic             CP,
  input  logic             CR,
  key_input_ctrl_if.slave  bus
);

  logic [NUM_KEYS-1:0] raw_n;
  logic [NUM_KEYS-1:0] stable_n;
  logic                mode_stable_d;
  logic                mode_press;
  logic [MODE_W-1:0]   mode;

  assign raw_n[KEY_MODE] = bus.ModeKeyRaw;
  assign raw_n[KEY_RESH] = bus.ResHKeyRaw;
  assign raw_n[KEY_RESL] = bus.ResLKeyRaw;
  assign raw_n[KEY_ADDH] = bus.AddHKeyRaw;
  assign raw_n[KEY_ADDL] = bus.AddLKeyRaw;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .CP       (CP),
      .CR       (CR),
      .SampleEn (bus.SampleEn),
      .raw_n    (raw_n[k]),
      .stable_n (stable_n[k])
    );
  end

  // Press = stable mode level falling 1 -> 0; high for the one cycle between
  // the debouncer flipping and the delayed copy catching up.
  assign mode_press = mode_stable_d & ~stable_n[KEY_MODE];

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      mode_stable_d <= 1'b1;
      mode          <= MODE_NORMAL;
    end else begin
      mode_stable_d <= stable_n[KEY_MODE];
      if (mode_press) mode <= next_mode(mode, MODE_W'(MODE_MAX));
    end
  end

  assign bus.Mode      = mode;
  assign bus.ModePulse = mode_press;
  // Clears are presented active-high; advances stay active-low for the consumer.
  assign bus.ResH      = ~stable_n[KEY_RESH];
  assign bus.ResL      = ~stable_n[KEY_RESL];
  assign bus.AddHKey   = stable_n[KEY_ADDH];
  assign bus.AddLKey   = stable_n[KEY_ADDL];

endmodule

// File: tb/tb_key_input_ctrl.sv
// Scoreboard bench for key_input_ctrl (DEB_CNT = 4, MODE_MAX = 5).
// A reference model predicts every output change (level flips and mode
// pulses) with the cycle it should appear in; a monitor compares DUT output
// changes against that queue.
module tb_key_input_ctrl;
  import key_input_ctrl_pkg::*;

  localparam int DEB  = 4;
  localparam int MMAX = 5;

  logic CP = 1'b0;
  logic CR = 1'b0;

  key_input_ctrl_if bus ();

  key_input_ctrl #(.DEB_CNT(DEB), .MODE_MAX(MMAX)) dut (
    .CP  (CP),
    .CR  (CR),
    .bus (bus)
  );

  always #5 CP = ~CP;

  typedef struct {
    int cyc;
    int key;
    int val;  // level for level keys, Mode during the pulse for KEY_MODE
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  bit  armed    = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic m_stable[NUM_KEYS] = '{default: 1'b1};
  int   m_run[NUM_KEYS]    = '{default: 0};
  logic m_dly[NUM_KEYS][$];
  int   m_mode = 0;

  function automatic logic out_of(input int k, input logic st);
    return (k == KEY_RESH || k == KEY_RESL) ? ~st : st;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NUM_KEYS; k++) begin
      m_stable[k] = 1'b1;
      m_run[k]    = 0;
      m_dly[k]    = {1'b1, 1'b1};
    end
    m_mode = 0;
  endfunction

  // Reset asserted between edges: any pressed level key is released at once,
  // visible at the next monitor sample.
  function automatic void model_reset_events();
    for (int k = 1; k < NUM_KEYS; k++)
      if (m_stable[k] == 1'b0) exp_q.push_back('{cyc + 1, k, int'(out_of(k, 1'b1))});
    model_clear();
  endfunction

  function automatic logic raw_of(input int k);
    case (k)
      KEY_MODE: return bus.ModeKeyRaw;
      KEY_RESH: return bus.ResHKeyRaw;
      KEY_RESL: return bus.ResLKeyRaw;
      KEY_ADDH: return bus.AddHKeyRaw;
      default:  return bus.AddLKeyRaw;
    endcase
  endfunction

  // A raw level is seen by the filter two cycles late; it must then disagree
  // with the stable level for DEB consecutive ticks to be accepted.
  always @(posedge CP) begin
    logic seen;
    logic now_raw[NUM_KEYS];
    for (int k = 0; k < NUM_KEYS; k++) now_raw[k] = raw_of(k);
    cyc++;
    if (CR) begin
      model_clear();
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        seen = m_dly[k].pop_front();
        m_dly[k].push_back(now_raw[k]);
        if (seen == m_stable[k]) begin
          m_run[k] = 0;
        end else if (bus.SampleEn) begin
          m_run[k]++;
          if (m_run[k] == DEB) begin
            m_run[k]    = 0;
            m_stable[k] = seen;
            if (k == KEY_MODE) begin
              if (seen == 1'b0) begin
                exp_q.push_back('{cyc, KEY_MODE, m_mode});
                m_mode = (m_mode == MMAX) ? 0 : m_mode + 1;
              end
            end else begin
              exp_q.push_back('{cyc, k, int'(out_of(k, seen))});
            end
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int prev[NUM_KEYS];

  always @(posedge CP) begin
    int  act[NUM_KEYS];
    ev_t e;
    #1;
    if (armed) begin
      act[KEY_MODE] = int'(bus.ModePulse);
      act[KEY_RESH] = int'(bus.ResH);
      act[KEY_RESL] = int'(bus.ResL);
      act[KEY_ADDH] = int'(bus.AddHKey);
      act[KEY_ADDL] = int'(bus.AddLKey);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_event: key %0d got no change, expected value %0d at cycle %0d",
                 e.key, e.val, e.cyc);
      end
      for (int k = 0; k < NUM_KEYS; k++) begin
        if ((k == KEY_MODE) ? (act[k] == 1) : (act[k] != prev[k])) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: key %0d changed to %0d at cycle %0d, expected no change",
                     k, act[k], cyc);
          end else begin
            e = exp_q.pop_front();
            check("event_key", k, e.key);
            check("event_cycle", cyc, e.cyc);
            if (k == KEY_MODE) check("mode_at_pulse", int'(bus.Mode), e.val);
            else               check("level", act[k], e.val);
          end
        end
        prev[k] = act[k];
      end
    end
  end

  // ---------------- stimulus ----------------
  int se_mode = 0;  // 0: every cycle, 1: every 10th cycle, 2: random
  int se_div  = 0;

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge CP);
      case (se_mode)
        0:       bus.SampleEn = 1'b1;
        1: begin bus.SampleEn = (se_div == 0); se_div = (se_div + 1) % 10; end
        default: bus.SampleEn = ($urandom_range(0, 3) == 0);
      endcase
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mode"},   int'(bus.Mode), 0);
    check({tag, "_pulse"},  int'(bus.ModePulse), 0);
    check({tag, "_resh"},   int'(bus.ResH), 0);
    check({tag, "_resl"},   int'(bus.ResL), 0);
    check({tag, "_addh"},   int'(bus.AddHKey), 1);
    check({tag, "_addl"},   int'(bus.AddLKey), 1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CP);
    CR = 1'b1;
    model_reset_events();
    #1;
    check_reset_outputs(tag);
    repeat (2) @(negedge CP);
    CR = 1'b0;
  endtask

  task automatic release_all();
    bus.ModeKeyRaw = 1'b1;
    bus.ResHKeyRaw = 1'b1;
    bus.ResLKeyRaw = 1'b1;
    bus.AddHKeyRaw = 1'b1;
    bus.AddLKeyRaw = 1'b1;
  endtask

  task automatic press_mode(input int hold);
    bus.ModeKeyRaw = 1'b0;
    cycles(hold);
    bus.ModeKeyRaw = 1'b1;
    cycles(12);
  endtask

  initial begin
    release_all();
    bus.SampleEn = 1'b0;
    #2 CR = 1'b1;
    model_clear();
    repeat (3) @(negedge CP);
    check_reset_outputs("init_reset");
    prev = '{0, 0, 0, 1, 1};
    armed = 1;
    CR = 1'b0;

    // Clean press held 110 cycles: one pulse only.
    se_mode = 0;
    cycles(5);
    press_mode(110);

    // Wrap: from reset, six presses give 1,2,3,4,5,0.
    do_reset("reset_before_wrap");
    cycles(5);
    for (int i = 0; i < 6; i++) press_mode(10);
    check("mode_after_wrap", int'(bus.Mode), m_mode);

    // Bounce on ResL: 3 sampled lows then high, five times, then steady low.
    for (int i = 0; i < 5; i++) begin
      bus.ResLKeyRaw = 1'b0; cycles(3);
      bus.ResLKeyRaw = 1'b1; cycles(3);
    end
    bus.ResLKeyRaw = 1'b0; cycles(12);
    bus.ResLKeyRaw = 1'b1; cycles(12);

    // Sparse ticks on AddH.
    se_mode = 1; se_div = 0;
    bus.AddHKeyRaw = 1'b0; cycles(60);
    bus.AddHKeyRaw = 1'b1; cycles(60);

    // Reset in the middle of AddL's count; key stays held across reset.
    se_div = 0;
    bus.AddLKeyRaw = 1'b0; cycles(25);
    do_reset("reset_mid_count");
    cycles(60);
    bus.AddLKeyRaw = 1'b1; cycles(60);

    // Random traffic on all keys with random ticks, one reset in the middle.
    se_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) bus.ModeKeyRaw = ~bus.ModeKeyRaw;
      if ($urandom_range(0, 29) == 0) bus.ResHKeyRaw = ~bus.ResHKeyRaw;
      if ($urandom_range(0, 29) == 0) bus.ResLKeyRaw = ~bus.ResLKeyRaw;
      if ($urandom_range(0, 29) == 0) bus.AddHKeyRaw = ~bus.AddHKeyRaw;
      if ($urandom_range(0, 29) == 0) bus.AddLKeyRaw = ~bus.AddLKeyRaw;
      if (i == 2000) do_reset("reset_random");
      cycles(1);
    end

    // Drain: release everything and let pending events settle.
    release_all();
    se_mode = 0;
    cycles(40);
    check("events_left", exp_q.size(), 0);
    check("mode_final", int'(bus.Mode), m_mode);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
